// File: rtl/sat_accum_pkg.sv
// sat_accum_pkg: shared types and helpers for the sat_accum_ctrl block.
//   state_e    : sequencer states (IDLE, ACCUM, DONE)
//   sym_max    : largest legal value of a symmetric signed range of a given width
//   sym_min    : smallest legal value, -sym_max (the most-negative pattern is illegal)
//   cnt_width  : term counter width, ceil(log2(n)) with a minimum of 1
package sat_accum_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } state_e;

   function automatic int sym_max(input int unsigned width);
      return (1 << (width - 1)) - 1;
   endfunction

   function automatic int sym_min(input int unsigned width);
      return -sym_max(width);
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sat_add.sv
// sat_add: combinational WIDTH-bit signed saturating adder, symmetric range.
//   a_i        in  WIDTH  accumulator operand (always legal)
//   b_i        in  WIDTH  incoming term; the illegal pattern is read as the minimum
//   result_o   out WIDTH  saturated, illegal-pattern-corrected sum
//   overflow_o out 1      signed overflow of the add (correction alone does not set it)
module sat_add
   import sat_accum_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] result_o,
   output logic             overflow_o
);

   localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(sym_max(WIDTH));
   localparam logic [WIDTH-1:0] MIN_V   = WIDTH'(sym_min(WIDTH));
   localparam logic [WIDTH-1:0] ILLEGAL = {1'b1, {(WIDTH - 1){1'b0}}};

   logic [WIDTH-1:0] b_fix;
   logic [WIDTH:0]   sum;
   logic             ovf;

   always_comb begin
      b_fix = (b_i == ILLEGAL) ? MIN_V : b_i;
      sum   = {1'b0, a_i} + {1'b0, b_fix};
      // Signed overflow: operands agree in sign, result sign differs.
      ovf   = (a_i[WIDTH-1] == b_fix[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      if (ovf) begin
         // Carry out distinguishes the two-negative case from the two-positive case.
         result_o = sum[WIDTH] ? MIN_V : MAX_V;
      end else if (sum[WIDTH-1:0] == ILLEGAL) begin
         result_o = MIN_V;
      end else begin
         result_o = sum[WIDTH-1:0];
      end
      overflow_o = ovf;
   end

endmodule

// File: rtl/sat_accum_ctrl.sv
// sat_accum_ctrl: sequences N_TERMS signed products through the shared
// saturating adder and presents the dot-product result on a handshake.
//   clk_80, reset_n_80          clock, asynchronous active-low reset
//   start_80                    begin a new dot product (IDLE, or DONE with acc_ready_80)
//   term_80/_valid_80/_ready_80 incoming term stream
//   acc_80/_valid_80/_ready_80  registered result stream
//   busy_80                     high in ACCUM and DONE
//   sat_flag_80                 sticky overflow flag, only when SAT_FLAG_EN is defined
module sat_accum_ctrl
   import sat_accum_pkg::*;
#(
   parameter int unsigned WIDTH_SUM = 4,
   parameter int unsigned N_TERMS   = 4
) (
   input  logic                 clk_80,
   input  logic                 reset_n_80,
   input  logic                 start_80,
   input  logic [WIDTH_SUM-1:0] term_80,
   input  logic                 term_valid_80,
   output logic                 term_ready_80,
   output logic [WIDTH_SUM-1:0] acc_80,
   output logic                 acc_valid_80,
   input  logic                 acc_ready_80,
   output logic                 busy_80
`ifdef SAT_FLAG_EN
   ,output logic                sat_flag_80
`endif
);

   localparam int unsigned      CNT_W    = cnt_width(N_TERMS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS - 1);

   state_e               state_q, state_d;
   logic [WIDTH_SUM-1:0] acc_q, acc_d;
   logic [WIDTH_SUM-1:0] sum;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 clear;

`ifdef SAT_FLAG_EN
   logic sat_q, sat_d;
   logic add_ovf;
`else
   logic unused_add_ovf;
`endif

   sat_add #(
      .WIDTH (WIDTH_SUM)
   ) u_sat_add (
      .a_i        (acc_q),
      .b_i        (term_80),
      .result_o   (sum),
`ifdef SAT_FLAG_EN
      .overflow_o (add_ovf)
`else
      .overflow_o (unused_add_ovf)
`endif
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      clear   = 1'b0;
`ifdef SAT_FLAG_EN
      sat_d   = sat_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start_80) begin
               clear   = 1'b1;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            // term_ready_80 is high throughout ACCUM, so valid alone means accept.
            if (term_valid_80) begin
               acc_d = sum;
               cnt_d = cnt_q + CNT_W'(1);
`ifdef SAT_FLAG_EN
               sat_d = sat_q | add_ovf;
`endif
               if (cnt_q == CNT_LAST) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (acc_ready_80) begin
               if (start_80) begin
                  clear   = 1'b1;
                  state_d = ACCUM;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (clear) begin
         acc_d = '0;
         cnt_d = '0;
`ifdef SAT_FLAG_EN
         sat_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk_80 or negedge reset_n_80) begin
      if (!reset_n_80) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
`ifdef SAT_FLAG_EN
         sat_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
`ifdef SAT_FLAG_EN
         sat_q   <= sat_d;
`endif
      end
   end

   assign term_ready_80 = (state_q == ACCUM);
   assign acc_valid_80  = (state_q == DONE);
   assign busy_80       = (state_q == ACCUM) || (state_q == DONE);
   assign acc_80        = acc_q;
`ifdef SAT_FLAG_EN
   assign sat_flag_80   = sat_q;
`endif

endmodule

// File: tb/tb_sat_accum_ctrl.sv
// tb_sat_accum_ctrl: self-checking bench for sat_accum_ctrl (WIDTH_SUM=4, N_TERMS=4).
// Flag checks are active when SAT_FLAG_EN is defined for both bench and design.
module tb_sat_accum_ctrl;

   localparam int W  = 4;
   localparam int N  = 4;
   localparam int HI = (1 << (W - 1)) - 1;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] term;
   logic         tv;
   logic         tr;
   logic [W-1:0] acc;
   logic         av;
   logic         ar;
   logic         busy;
`ifdef SAT_FLAG_EN
   logic         sat;
`endif

   always #5 clk = ~clk;

   sat_accum_ctrl #(
      .WIDTH_SUM (W),
      .N_TERMS   (N)
   ) dut (
      .clk_80        (clk),
      .reset_n_80    (rst_n),
      .start_80      (start),
      .term_80       (term),
      .term_valid_80 (tv),
      .term_ready_80 (tr),
      .acc_80        (acc),
      .acc_valid_80  (av),
      .acc_ready_80  (ar),
      .busy_80       (busy)
`ifdef SAT_FLAG_EN
      ,.sat_flag_80  (sat)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef int terms_t [N];

   typedef struct {
      terms_t terms;
      int     exp_acc;
      bit     exp_sat;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_sat(input string name, input bit exp);
`ifdef SAT_FLAG_EN
      check(name, int'(sat), int'(exp));
`else
      if (exp === 1'bx) $display("unreachable %s", name);
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: clamp the exact integer sum into the symmetric range.
   function automatic void model(input terms_t t, output int res, output bit flag);
      int v;
      int s;
      res  = 0;
      flag = 1'b0;
      for (int i = 0; i < N; i++) begin
         v = (t[i] == -(HI + 1)) ? -HI : t[i];
         s = res + v;
         if (s > HI || s < -(HI + 1)) flag = 1'b1;
         res = (s > HI) ? HI : ((s < -HI) ? -HI : s);
      end
   endfunction

   task automatic feed_terms(input terms_t t, input int gmin, input int gmax, input bit rs);
      int g;
      for (int k = 0; k < N; k++) begin
         g  = int'($urandom_range(gmax, gmin));
         tv = 1'b0;
         repeat (g) begin
            start = rs ? 1'($urandom_range(1, 0)) : 1'b0;
            tick();
         end
         check("term_ready_in_accum", int'(tr), 1);
         check("busy_in_accum", int'(busy), 1);
         check("acc_valid_in_accum", int'(av), 0);
         tv    = 1'b1;
         term  = t[k][W-1:0];
         start = rs ? 1'($urandom_range(1, 0)) : 1'b0;
         tick();
      end
      tv    = 1'b0;
      start = 1'b0;
   endtask

   task automatic finish_result(input int exp_acc, input bit exp_sat, input int delay, input bit rs);
      check("acc_valid_done", int'(av), 1);
      check("acc_value", int'($signed(acc)), exp_acc);
      check_sat("sat_flag", exp_sat);
      check("term_ready_done", int'(tr), 0);
      repeat (delay) begin
         ar    = 1'b0;
         start = rs ? 1'($urandom_range(1, 0)) : 1'b0;
         tick();
         check("acc_valid_held", int'(av), 1);
         check("acc_held", int'($signed(acc)), exp_acc);
      end
      ar    = 1'b1;
      start = 1'b0;
      tick();
      ar    = 1'b0;
      check("acc_valid_after_take", int'(av), 0);
      check("busy_idle", int'(busy), 0);
      check("term_ready_idle", int'(tr), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t   vecs[6];
      terms_t t;
      int     exp_acc;
      bit     exp_sat;

      vecs[0].terms = '{3, 2, 1, 1};    vecs[0].exp_acc = 7;  vecs[0].exp_sat = 1'b0;
      vecs[1].terms = '{5, 4, -1, 1};   vecs[1].exp_acc = 7;  vecs[1].exp_sat = 1'b1;
      vecs[2].terms = '{-5, -4, 0, 0};  vecs[2].exp_acc = -7; vecs[2].exp_sat = 1'b1;
      vecs[3].terms = '{-8, 0, 0, 0};   vecs[3].exp_acc = -7; vecs[3].exp_sat = 1'b0;
      vecs[4].terms = '{-7, -1, 0, 0};  vecs[4].exp_acc = -7; vecs[4].exp_sat = 1'b0;
      vecs[5].terms = '{7, -7, 3, -3};  vecs[5].exp_acc = 0;  vecs[5].exp_sat = 1'b0;

      rst_n = 1'b0;
      start = 1'b0;
      tv    = 1'b0;
      term  = '0;
      ar    = 1'b0;
      #12;
      check("reset_acc", int'(acc), 0);
      check("reset_acc_valid", int'(av), 0);
      check("reset_term_ready", int'(tr), 0);
      check("reset_busy", int'(busy), 0);
      check_sat("reset_sat", 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("idle_term_ready", int'(tr), 0);

      // Full-rate table: result must appear exactly N+1 edges after start.
      foreach (vecs[i]) begin
         start = 1'b1;
         tick();
         start = 1'b0;
         feed_terms(vecs[i].terms, 0, 0, 1'b0);
         finish_result(vecs[i].exp_acc, vecs[i].exp_sat, 0, 1'b0);
      end

      // Stalled input, backpressured output, then back-to-back restart.
      t = '{1, 1, 1, 1};
      start = 1'b1;
      tick();
      start = 1'b0;
      feed_terms(t, 1, 1, 1'b0);
      check("stall_acc_valid", int'(av), 1);
      check("stall_acc", int'($signed(acc)), 4);
      repeat (3) begin
         tick();
         check("bp_acc_valid", int'(av), 1);
         check("bp_acc", int'($signed(acc)), 4);
      end
      ar    = 1'b1;
      start = 1'b1;
      tick();
      ar    = 1'b0;
      start = 1'b0;
      check("b2b_term_ready", int'(tr), 1);
      check("b2b_acc_valid", int'(av), 0);
      check("b2b_acc_cleared", int'(acc), 0);
      t = '{2, 0, 0, 1};
      feed_terms(t, 0, 0, 1'b0);
      finish_result(3, 1'b0, 0, 1'b0);

      // Asynchronous reset after the second term.
      start = 1'b1;
      tick();
      start = 1'b0;
      tv    = 1'b1;
      term  = 4'd2;
      tick();
      term  = 4'd3;
      tick();
      tv    = 1'b0;
      check("pre_reset_acc", int'(acc), 5);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_acc", int'(acc), 0);
      check("async_rst_term_ready", int'(tr), 0);
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_acc_valid", int'(av), 0);
      check_sat("async_rst_sat", 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) begin
         tick();
         check("post_rst_no_result", int'(av), 0);
         check("post_rst_idle", int'(busy), 0);
      end
      t = '{0, 0, 0, 0};
      start = 1'b1;
      tick();
      start = 1'b0;
      feed_terms(t, 0, 0, 1'b0);
      finish_result(0, 1'b0, 0, 1'b0);

      // Randomised dot products with stalls, backpressure and stray starts.
      for (int it = 0; it < 40; it++) begin
         for (int k = 0; k < N; k++) t[k] = int'($urandom_range(15, 0)) - 8;
         model(t, exp_acc, exp_sat);
         start = 1'b1;
         tick();
         start = 1'b0;
         feed_terms(t, 0, 2, 1'b1);
         finish_result(exp_acc, exp_sat, int'($urandom_range(3, 0)), 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
